// File: rtl/adapter_pkg.sv
// Shared types and helpers for the parametrised wide-to-narrow bus adapter.
// A slot is stored at the widest supported layout; narrower builds leave the upper bits at zero.
package adapter_pkg;

  localparam int unsigned MAX_IN_WIDTH = 32'd1024;
  localparam int unsigned REMAIN_W     = $clog2(MAX_IN_WIDTH + 32'd1);

  typedef struct packed {
    logic [MAX_IN_WIDTH-1:0] data;
    logic [REMAIN_W-1:0]     remain;
  } slot_t;

  function automatic int unsigned ratio(input int unsigned in_width, input int unsigned out_width);
    return in_width / out_width;
  endfunction

  function automatic int unsigned remain_width(input int unsigned r);
    return $clog2(r + 32'd1);
  endfunction

  function automatic int unsigned beats_clamp(input int unsigned length, input int unsigned r);
    return (length > r) ? r : length;
  endfunction

endpackage

// File: rtl/param_adapter_to_bus_if.sv
// Wide-in / narrow-out enqueue handshake bundle for param_adapter_to_bus.
// master = the adapter, slave = the producer plus bus environment.
interface param_adapter_to_bus_if #(
  parameter int unsigned IN_WIDTH  = 32'd128,
  parameter int unsigned OUT_WIDTH = 32'd32,
  parameter int unsigned LEN_WIDTH = 32'd16
);
  logic                 in_enq__ENA;
  logic [IN_WIDTH-1:0]  in_enq_v;
  logic [LEN_WIDTH-1:0] in_enq_length;
  logic                 in_enq__RDY;
  logic                 out_enq__ENA;
  logic [OUT_WIDTH-1:0] out_enq_v;
  logic                 out_enq_last;
  logic                 out_enq__RDY;

  modport master (
    input  in_enq__ENA, in_enq_v, in_enq_length,
    output in_enq__RDY,
    output out_enq__ENA, out_enq_v, out_enq_last,
    input  out_enq__RDY
  );

  modport slave (
    output in_enq__ENA, in_enq_v, in_enq_length,
    input  in_enq__RDY,
    input  out_enq__ENA, out_enq_v, out_enq_last,
    output out_enq__RDY
  );
endinterface

// File: rtl/adapter_slot.sv
// One message slot: shift buffer plus remaining-beat counter with load, clear and shift.
// Priority is load, then clear, then shift.
module adapter_slot
  import adapter_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32'd128,
  parameter int unsigned OUT_WIDTH = 32'd32,
  parameter int unsigned RW        = 32'd3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  load_data,
  input  logic [RW-1:0]        load_beats,
  input  logic                 clear,
  input  logic                 shift,
  output logic [IN_WIDTH-1:0]  data,
  output logic [RW-1:0]        remain,
  output logic [OUT_WIDTH-1:0] head
);

  slot_t               slot_r;
  slot_t               slot_n;
  logic [IN_WIDTH-1:0] cur_s;
  logic [IN_WIDTH-1:0] shifted_s;
  logic                unused_slot_s;

  assign cur_s         = slot_r.data[IN_WIDTH-1:0];
  assign data          = cur_s;
  assign remain        = slot_r.remain[RW-1:0];
  assign head          = MSB_FIRST ? cur_s[IN_WIDTH-1 -: OUT_WIDTH] : cur_s[OUT_WIDTH-1:0];
  // Consumed words leave at the output end; zeros enter at the far end.
  assign shifted_s     = MSB_FIRST ? (cur_s << OUT_WIDTH) : (cur_s >> OUT_WIDTH);
  assign unused_slot_s = ^slot_r;

  // Next-state selection for the slot contents.
  always_comb begin
    slot_n = slot_r;
    if (load) begin
      slot_n                      = '0;
      slot_n.data[IN_WIDTH-1:0]   = load_data;
      slot_n.remain[RW-1:0]       = load_beats;
    end else if (clear) begin
      slot_n = '0;
    end else if (shift) begin
      slot_n.data[IN_WIDTH-1:0] = shifted_s;
      slot_n.remain             = slot_r.remain - REMAIN_W'(1'b1);
    end else begin
      slot_n = slot_r;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_r <= '0;
    end else begin
      slot_r <= slot_n;
    end
  end

endmodule

// File: rtl/param_adapter_to_bus.sv
// Parametrised wide-to-narrow serializer: one wide message in, up to IN_WIDTH/OUT_WIDTH beats out.
// Define ADAPTER_TO_BUS_PREFETCH_EN to add a next slot for bubble-free back-to-back messages.
module param_adapter_to_bus
  import adapter_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32'd128,
  parameter int unsigned OUT_WIDTH = 32'd32,
  parameter int unsigned LEN_WIDTH = 32'd16,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                          CLK,
  input  logic                          nRST,
  param_adapter_to_bus_if.master        bus
);

  localparam int unsigned R  = ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned RW = remain_width(R);

  if (((IN_WIDTH % OUT_WIDTH) != 32'd0) || (R < 32'd2) ||
      (IN_WIDTH > MAX_IN_WIDTH) || (LEN_WIDTH > 32'd32)) begin : g_bad_cfg
    $error("param_adapter_to_bus: IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
  end

  logic                 xfer_s;
  logic                 last_xfer_s;
  logic                 accept_s;
  logic                 live_s;
  logic                 in_rdy_s;
  logic [RW-1:0]        beats_s;
  logic [RW-1:0]        cur_remain_s;
  logic [OUT_WIDTH-1:0] cur_head_s;
  logic [IN_WIDTH-1:0]  unused_cur_data_s;
  logic                 cur_load_s;
  logic [IN_WIDTH-1:0]  cur_load_data_s;
  logic [RW-1:0]        cur_load_beats_s;

  assign xfer_s      = bus.out_enq__ENA & bus.out_enq__RDY;
  assign last_xfer_s = xfer_s & (cur_remain_s == RW'(1'b1));
  assign accept_s    = bus.in_enq__ENA & in_rdy_s;
  // Zero-length messages are consumed by the handshake but never reach a slot.
  assign live_s      = accept_s & (bus.in_enq_length != '0);
  assign beats_s     = RW'(beats_clamp(32'(bus.in_enq_length), R));

  assign bus.in_enq__RDY  = in_rdy_s;
  assign bus.out_enq__ENA = (cur_remain_s != '0);
  assign bus.out_enq_v    = cur_head_s;
  assign bus.out_enq_last = (cur_remain_s == RW'(1'b1));

`ifdef ADAPTER_TO_BUS_PREFETCH_EN
  logic [RW-1:0]        nxt_remain_s;
  logic [IN_WIDTH-1:0]  nxt_data_s;
  logic [OUT_WIDTH-1:0] unused_nxt_head_s;
  logic                 nvalid_s;
  logic                 promote_s;
  logic                 take_cur_s;
  logic                 nxt_load_s;
  logic                 nxt_clear_s;

  assign nvalid_s         = (nxt_remain_s != '0);
  assign in_rdy_s         = !nvalid_s;
  assign promote_s        = last_xfer_s & nvalid_s;
  // The current slot takes the new message only if nothing is queued ahead of it.
  assign take_cur_s       = live_s & ((cur_remain_s == '0) | (last_xfer_s & !nvalid_s));
  assign nxt_load_s       = live_s & !take_cur_s;
  assign nxt_clear_s      = promote_s & !nxt_load_s;
  assign cur_load_s       = take_cur_s | promote_s;
  assign cur_load_data_s  = promote_s ? nxt_data_s : bus.in_enq_v;
  assign cur_load_beats_s = promote_s ? nxt_remain_s : beats_s;

  adapter_slot #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .RW        (RW),
    .MSB_FIRST (MSB_FIRST)
  ) u_next (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (nxt_load_s),
    .load_data  (bus.in_enq_v),
    .load_beats (beats_s),
    .clear      (nxt_clear_s),
    .shift      (1'b0),
    .data       (nxt_data_s),
    .remain     (nxt_remain_s),
    .head       (unused_nxt_head_s)
  );
`else
  assign in_rdy_s         = (cur_remain_s == '0);
  assign cur_load_s       = live_s;
  assign cur_load_data_s  = bus.in_enq_v;
  assign cur_load_beats_s = beats_s;
`endif

  adapter_slot #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .RW        (RW),
    .MSB_FIRST (MSB_FIRST)
  ) u_cur (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (cur_load_s),
    .load_data  (cur_load_data_s),
    .load_beats (cur_load_beats_s),
    .clear      (1'b0),
    .shift      (xfer_s),
    .data       (unused_cur_data_s),
    .remain     (cur_remain_s),
    .head       (cur_head_s)
  );

endmodule

// File: tb/tb_param_adapter_to_bus.sv
// Directed bench for param_adapter_to_bus: LSB-first 128/32, MSB-first 128/32 and LSB-first 64/16.
module tb_param_adapter_to_bus;

`ifdef ADAPTER_TO_BUS_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  localparam logic [127:0] MSG_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] MSG_B = 128'h88888888_77777777_66666666_55555555;

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   xfer0  = 0;
  int   last0  = 0;

  param_adapter_to_bus_if #(.IN_WIDTH(128), .OUT_WIDTH(32), .LEN_WIDTH(16)) if0 ();
  param_adapter_to_bus_if #(.IN_WIDTH(128), .OUT_WIDTH(32), .LEN_WIDTH(16)) if1 ();
  param_adapter_to_bus_if #(.IN_WIDTH(64),  .OUT_WIDTH(16), .LEN_WIDTH(16)) if2 ();

  param_adapter_to_bus #(.IN_WIDTH(128), .OUT_WIDTH(32), .LEN_WIDTH(16), .MSB_FIRST(1'b0))
    dut0 (.CLK(CLK), .nRST(nRST), .bus(if0));
  param_adapter_to_bus #(.IN_WIDTH(128), .OUT_WIDTH(32), .LEN_WIDTH(16), .MSB_FIRST(1'b1))
    dut1 (.CLK(CLK), .nRST(nRST), .bus(if1));
  param_adapter_to_bus #(.IN_WIDTH(64), .OUT_WIDTH(16), .LEN_WIDTH(16), .MSB_FIRST(1'b0))
    dut2 (.CLK(CLK), .nRST(nRST), .bus(if2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count dut0 transfers and last-beat transfers, sampled mid-cycle.
  always @(negedge CLK) begin
    if (if0.out_enq__ENA && if0.out_enq__RDY) begin
      xfer0 <= xfer0 + 1;
      if (if0.out_enq_last) last0 <= last0 + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer0(input logic [127:0] v, input logic [15:0] len);
    if0.in_enq__ENA   = 1'b1;
    if0.in_enq_v      = v;
    if0.in_enq_length = len;
    step();
    if0.in_enq__ENA   = 1'b0;
  endtask

  initial begin
    logic [31:0] exp32;
    logic [15:0] exp16;
    logic [9:0]  pattern;
    int          x_snap;
    int          l_snap;
    int          beat_n;
    logic        drop;

    nRST = 1'b0;
    if0.in_enq__ENA = 1'b0; if0.in_enq_v = '0; if0.in_enq_length = '0; if0.out_enq__RDY = 1'b1;
    if1.in_enq__ENA = 1'b0; if1.in_enq_v = '0; if1.in_enq_length = '0; if1.out_enq__RDY = 1'b1;
    if2.in_enq__ENA = 1'b0; if2.in_enq_v = '0; if2.in_enq_length = '0; if2.out_enq__RDY = 1'b1;
    step();
    step();
    chk("reset ena",  {127'd0, if0.out_enq__ENA}, 128'd0);
    chk("reset v",    {96'd0, if0.out_enq_v},     128'd0);
    chk("reset last", {127'd0, if0.out_enq_last}, 128'd0);
    chk("reset rdy",  {127'd0, if0.in_enq__RDY},  128'd1);
    nRST = 1'b1;
    step();
    chk("idle rdy", {127'd0, if0.in_enq__RDY},  128'd1);
    chk("idle ena", {127'd0, if0.out_enq__ENA}, 128'd0);

    // LSB-first, length 4, bus always ready
    offer0(MSG_A, 16'd4);
    chk("lsb rdy after accept", {127'd0, if0.in_enq__RDY}, {127'd0, PF});
    for (int k = 0; k < 4; k++) begin
      exp32 = 32'h11111111 * 32'(k + 1);
      chk($sformatf("lsb ena%0d", k),  {127'd0, if0.out_enq__ENA}, 128'd1);
      chk($sformatf("lsb beat%0d", k), {96'd0, if0.out_enq_v},     {96'd0, exp32});
      chk($sformatf("lsb last%0d", k), {127'd0, if0.out_enq_last}, {127'd0, (k == 3)});
      step();
    end
    chk("lsb done ena", {127'd0, if0.out_enq__ENA}, 128'd0);
    chk("lsb done rdy", {127'd0, if0.in_enq__RDY},  128'd1);

    // Back-pressure for three cycles after beat 2
    x_snap = xfer0; l_snap = last0;
    offer0(MSG_A, 16'd4);
    chk("stall beat0", {96'd0, if0.out_enq_v}, 128'h11111111);
    step();
    chk("stall beat1", {96'd0, if0.out_enq_v}, 128'h22222222);
    if0.out_enq__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall hold v%0d", i),    {96'd0, if0.out_enq_v},     128'h22222222);
      chk($sformatf("stall hold ena%0d", i),  {127'd0, if0.out_enq__ENA}, 128'd1);
      chk($sformatf("stall hold last%0d", i), {127'd0, if0.out_enq_last}, 128'd0);
    end
    if0.out_enq__RDY = 1'b1;
    step();
    chk("stall beat2", {96'd0, if0.out_enq_v}, 128'h33333333);
    step();
    chk("stall beat3", {96'd0, if0.out_enq_v}, 128'h44444444);
    chk("stall last3", {127'd0, if0.out_enq_last}, 128'd1);
    step();
    chk("stall xfers", 128'(xfer0 - x_snap), 128'd4);
    chk("stall lasts", 128'(last0 - l_snap), 128'd1);

    // Zero length is dropped
    x_snap = xfer0;
    offer0(MSG_A, 16'd0);
    chk("len0 ena", {127'd0, if0.out_enq__ENA}, 128'd0);
    chk("len0 rdy", {127'd0, if0.in_enq__RDY},  128'd1);
    step();
    step();
    chk("len0 xfers", 128'(xfer0 - x_snap), 128'd0);

    // Length 9 is clamped to 4 beats
    x_snap = xfer0; l_snap = last0;
    offer0(MSG_A, 16'd9);
    for (int i = 0; i < 6; i++) step();
    chk("len9 xfers", 128'(xfer0 - x_snap), 128'd4);
    chk("len9 lasts", 128'(last0 - l_snap), 128'd1);
    chk("len9 idle",  {127'd0, if0.out_enq__ENA}, 128'd0);

    // Length 2
    offer0(MSG_A, 16'd2);
    chk("len2 beat0", {96'd0, if0.out_enq_v},     128'h11111111);
    chk("len2 last0", {127'd0, if0.out_enq_last}, 128'd0);
    step();
    chk("len2 beat1", {96'd0, if0.out_enq_v},     128'h22222222);
    chk("len2 last1", {127'd0, if0.out_enq_last}, 128'd1);
    step();
    chk("len2 idle",  {127'd0, if0.out_enq__ENA}, 128'd0);

    // Two length-4 messages offered back to back
    if0.in_enq__ENA = 1'b1; if0.in_enq_v = MSG_A; if0.in_enq_length = 16'd4;
    step();
    if0.in_enq_v = MSG_B;
    pattern = '0;
    beat_n  = 0;
    for (int c = 0; c < 10; c++) begin
      pattern[c] = if0.out_enq__ENA;
      if (if0.out_enq__ENA) begin
        exp32 = 32'h11111111 * 32'(beat_n + 1);
        chk($sformatf("b2b beat%0d", beat_n), {96'd0, if0.out_enq_v},     {96'd0, exp32});
        chk($sformatf("b2b last%0d", beat_n), {127'd0, if0.out_enq_last}, {127'd0, ((beat_n % 4) == 3)});
        beat_n++;
      end
      drop = if0.in_enq__ENA & if0.in_enq__RDY;
      step();
      if (drop) if0.in_enq__ENA = 1'b0;
    end
    chk("b2b beats",   128'(beat_n), 128'd8);
    chk("b2b pattern", {118'd0, pattern}, PF ? 128'h0FF : 128'h1EF);

    // Reset in the middle of a message
    l_snap = last0;
    offer0(MSG_A, 16'd4);
    step();
    nRST = 1'b0;
    step();
    chk("midrst ena",  {127'd0, if0.out_enq__ENA}, 128'd0);
    chk("midrst last", {127'd0, if0.out_enq_last}, 128'd0);
    chk("midrst v",    {96'd0, if0.out_enq_v},     128'd0);
    chk("midrst rdy",  {127'd0, if0.in_enq__RDY},  128'd1);
    nRST = 1'b1;
    step();
    step();
    chk("midrst lasts", 128'(last0 - l_snap), 128'd0);
    chk("midrst idle",  {127'd0, if0.out_enq__ENA}, 128'd0);

    // MSB-first instance
    if1.in_enq__ENA = 1'b1; if1.in_enq_v = MSG_A; if1.in_enq_length = 16'd4;
    step();
    if1.in_enq__ENA = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp32 = 32'h11111111 * 32'(4 - k);
      chk($sformatf("msb beat%0d", k), {96'd0, if1.out_enq_v},     {96'd0, exp32});
      chk($sformatf("msb last%0d", k), {127'd0, if1.out_enq_last}, {127'd0, (k == 3)});
      step();
    end
    chk("msb done ena", {127'd0, if1.out_enq__ENA}, 128'd0);

    // 64/16 instance
    if2.in_enq__ENA = 1'b1; if2.in_enq_v = 64'h4444_3333_2222_1111; if2.in_enq_length = 16'd4;
    step();
    if2.in_enq__ENA = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp16 = 16'h1111 * 16'(k + 1);
      chk($sformatf("w64 beat%0d", k), {112'd0, if2.out_enq_v},    {112'd0, exp16});
      chk($sformatf("w64 last%0d", k), {127'd0, if2.out_enq_last}, {127'd0, (k == 3)});
      step();
    end
    chk("w64 done ena", {127'd0, if2.out_enq__ENA}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
